knn_load_sequencer: RTL and testbench
=====================================

KNN_LOAD_SEQUENCER -- requirements
Module: knn_load_sequencer

Interface
REQ-001 Parameters (name, default, meaning): M 5 matrix rows; N 10 matrix columns; W 32 element width; MAX_ELEMENTS 32 lanes per burst; TYPE_W 3 class-label width; L 6 log2 of the training-sample count.
REQ-002 Derived constants: E = M*N elements per matrix; B = min(E, MAX_ELEMENTS) lanes per burst; NB = ceil(E/B) bursts per sample; S = 2^L samples.
REQ-003 clk in 1: single clock; all logic is rising-edge.
REQ-004 rst in 1: synchronous, active-high reset.
REQ-005 start in 1: one-cycle request to run a full load/inference pass.
REQ-006 busy out 1: high from the cycle after start is accepted until the cycle result_valid is asserted.
REQ-007 mem_rd_en out 1 and mem_addr out clog2(S*E): element read strobe and address; address = s*E + e.
REQ-008 type_addr out L: sample index s, driven with the sample's first element read.
REQ-009 mem_train_word in W, mem_input_word in W, mem_type in TYPE_W: read data, valid exactly 1 cycle after mem_rd_en.
REQ-010 training_data out W*MAX_ELEMENTS and input_data out W*MAX_ELEMENTS: burst buffers; lane j occupies bits [W*(j+1)-1 -: W].
REQ-011 training_data_type out TYPE_W: label of the current sample.
REQ-012 read_done out 1: one-cycle pulse meaning the burst buffers are valid.
REQ-013 data_request in 1 and done in 1: KNN core requests the next burst, or reports the sample consumed.
REQ-014 inference_done in 1 and inferred_type in TYPE_W: KNN core reports that classification has finished.
REQ-015 result_type out TYPE_W and result_valid out 1: captured classification and its one-cycle strobe.

Function
REQ-016 States SHALL be IDLE, FILL, DRAIN, STROBE, WAIT_REQ, WAIT_DONE, WAIT_INF and REPORT.
REQ-017 IDLE: start=1 -> FILL with s=0, burst b=0, lane j=0; start in any other state is ignored.
REQ-018 FILL: mem_rd_en=1 on each of L_b consecutive cycles, where L_b = min(B, E-b*B); after the last read -> DRAIN.
REQ-019 Lane j of the buffer is written 1 cycle after its read is issued; the label is captured 1 cycle after the e=b*B read when b=0.
REQ-020 On entering FILL, lanes j >= L_b are cleared to 0, so no stale data remains in a partial burst.
REQ-021 DRAIN: write the last lane -> STROBE; a burst therefore takes L_b+1 cycles from its first read to read_done.
REQ-022 STROBE: read_done=1 for exactly one cycle; the buffers are held stable until the next FILL; b<NB-1 -> WAIT_REQ, else -> WAIT_DONE.
REQ-023 WAIT_REQ: data_request=1 -> FILL with b+1; done is ignored in this state.
REQ-024 WAIT_DONE: done=1 -> s<S-1 ? FILL (s+1, b=0) : WAIT_INF; data_request is ignored in this state.
REQ-025 WAIT_INF: inference_done=1 -> REPORT, capturing inferred_type into result_type.
REQ-026 REPORT: result_valid=1 for exactly one cycle, busy=0 -> IDLE; result_type is held until the next REPORT.
REQ-027 Handshake inputs SHALL be sampled only in their waiting state, and a level held high across states SHALL NOT trigger twice.
REQ-028 The s, b and j counters SHALL saturate and never wrap during a pass; s wraps to 0 only on start.

Reset
REQ-029 rst=1 at a clock edge: state=IDLE, all outputs 0, buffers 0, and counters 0, including in the middle of a pass.
REQ-030 The first start is accepted on the first edge with rst=0.

Verification
REQ-031 Defaults, L=1, mem word = address: first burst lanes 0..31 = 0..31, read_done 33 cycles after the first read; second burst lanes 0..17 = 32..49 and lanes 18..31 = 0.
REQ-032 M=2, N=4: one 8-lane burst per sample; WAIT_REQ is never entered; data_request held high is ignored.
REQ-033 L=2, inference_done arriving with inferred_type=3 after the 4th done: result_type=3, result_valid high for one cycle, busy low in the same cycle.
REQ-034 rst asserted mid-FILL of sample 1: the next cycle shows IDLE, read_done=0 and buffers 0; a new start restarts at mem_addr 0.
REQ-035 start pulsed during WAIT_DONE and done pulsed during WAIT_REQ: no state or counter change.
REQ-036 mem_type = s+1 per sample: training_data_type equals s+1 at every read_done of sample s.

Source files
------------

// File: rtl/knn_load_sequencer_if.sv
// Bus between the KNN load sequencer (master) and its surroundings (slave):
// control handshakes, element-memory read port, burst buffers and result.
interface knn_load_sequencer_if #(
    parameter int M            = 5,
    parameter int N            = 10,
    parameter int W            = 32,
    parameter int MAX_ELEMENTS = 32,
    parameter int TYPE_W       = 3,
    parameter int L            = 6
);
    localparam int E  = M * N;
    localparam int S  = 1 << L;
    localparam int AW = $clog2(S * E);

    // pass control
    logic                      start;
    logic                      busy;
    // element / label memory read port
    logic                      mem_rd_en;
    logic [AW-1:0]             mem_addr;
    logic [L-1:0]              type_addr;
    logic [W-1:0]              mem_train_word;
    logic [W-1:0]              mem_input_word;
    logic [TYPE_W-1:0]         mem_type;
    // burst buffers towards the KNN core
    logic [W*MAX_ELEMENTS-1:0] training_data;
    logic [W*MAX_ELEMENTS-1:0] input_data;
    logic [TYPE_W-1:0]         training_data_type;
    logic                      read_done;
    // KNN core handshakes
    logic                      data_request;
    logic                      done;
    logic                      inference_done;
    logic [TYPE_W-1:0]         inferred_type;
    // classification result
    logic [TYPE_W-1:0]         result_type;
    logic                      result_valid;

    modport master (
        input  start, mem_train_word, mem_input_word, mem_type,
               data_request, done, inference_done, inferred_type,
        output busy, mem_rd_en, mem_addr, type_addr,
               training_data, input_data, training_data_type, read_done,
               result_type, result_valid
    );

    modport slave (
        output start, mem_train_word, mem_input_word, mem_type,
               data_request, done, inference_done, inferred_type,
        input  busy, mem_rd_en, mem_addr, type_addr,
               training_data, input_data, training_data_type, read_done,
               result_type, result_valid
    );
endinterface

// File: rtl/knn_load_sequencer.sv
// KNN load sequencer: streams every training sample (and the matching input
// elements) out of memory in bursts of up to MAX_ELEMENTS lanes, hands each
// burst to the KNN core, and finally captures the core's classification.
module knn_load_sequencer #(
    parameter int M            = 5,
    parameter int N            = 10,
    parameter int W            = 32,
    parameter int MAX_ELEMENTS = 32,
    parameter int TYPE_W       = 3,
    parameter int L            = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    knn_load_sequencer_if.master bus
);
    localparam int E  = M * N;
    localparam int B  = (E < MAX_ELEMENTS) ? E : MAX_ELEMENTS;
    localparam int NB = (E + B - 1) / B;
    localparam int S  = 1 << L;
    localparam int AW = $clog2(S * E);
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam int JW = $clog2(B + 1);

    typedef enum logic [2:0] {
        IDLE, FILL, DRAIN, STROBE, WAIT_REQ, WAIT_DONE, WAIT_INF, REPORT
    } state_t;

    // Number of lanes carried by burst b; only the last burst can be short.
    function automatic logic [JW-1:0] burst_len(input logic [BW-1:0] b);
        int rem;
        rem = E - int'(b) * B;
        return (rem < B) ? JW'(rem) : JW'(B);
    endfunction

    state_t             state_reg;
    logic [L-1:0]       s_reg;
    logic [BW-1:0]      b_reg;
    logic [JW-1:0]      j_reg;
    logic [JW-1:0]      len_reg;
    logic               mem_rd_en_reg;
    logic [AW-1:0]      mem_addr_reg;
    logic [L-1:0]       type_addr_reg;
    logic               busy_reg;
    logic               read_done_reg;
    logic               result_valid_reg;
    logic [TYPE_W-1:0]  result_type_reg;
    logic [TYPE_W-1:0]  train_type_reg;

    // read-return pipeline: data for the read issued last cycle is on the bus now
    logic               rd_pending_reg;
    logic [JW-1:0]      rd_lane_reg;
    logic               rd_first_reg;

    // a handshake level is consumed once and must drop before it can fire again
    logic               start_used_reg;
    logic               req_used_reg;
    logic               done_used_reg;
    logic               inf_used_reg;

    logic               start_fire;
    logic               req_fire;
    logic               done_fire;
    logic               inf_fire;
    logic               fill_enter;
    logic [BW-1:0]      fill_b_next;
    logic [JW-1:0]      fill_len_next;

    assign start_fire = bus.start          && !start_used_reg;
    assign req_fire   = bus.data_request   && !req_used_reg;
    assign done_fire  = bus.done           && !done_used_reg;
    assign inf_fire   = bus.inference_done && !inf_used_reg;

    // Decide whether a new burst starts this cycle and which burst it is.
    always_comb begin
        fill_enter  = 1'b0;
        fill_b_next = '0;
        case (state_reg)
            IDLE:      fill_enter = start_fire;
            WAIT_REQ: begin
                fill_enter  = req_fire;
                fill_b_next = (b_reg == BW'(NB - 1)) ? b_reg : b_reg + BW'(1);
            end
            WAIT_DONE: fill_enter = done_fire && (s_reg != L'(S - 1));
            default:   ;
        endcase
    end

    assign fill_len_next = burst_len(fill_b_next);

    // Pass sequencing, counters, memory addressing and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            s_reg            <= '0;
            b_reg            <= '0;
            j_reg            <= '0;
            len_reg          <= '0;
            mem_rd_en_reg    <= 1'b0;
            mem_addr_reg     <= '0;
            type_addr_reg    <= '0;
            busy_reg         <= 1'b0;
            read_done_reg    <= 1'b0;
            result_valid_reg <= 1'b0;
            result_type_reg  <= '0;
            train_type_reg   <= '0;
            rd_pending_reg   <= 1'b0;
            rd_lane_reg      <= '0;
            rd_first_reg     <= 1'b0;
            start_used_reg   <= 1'b0;
            req_used_reg     <= 1'b0;
            done_used_reg    <= 1'b0;
            inf_used_reg     <= 1'b0;
        end else begin
            read_done_reg    <= 1'b0;
            result_valid_reg <= 1'b0;

            rd_pending_reg <= mem_rd_en_reg;
            rd_lane_reg    <= j_reg;
            rd_first_reg   <= mem_rd_en_reg && (b_reg == '0) && (j_reg == '0);
            if (rd_pending_reg && rd_first_reg) begin
                train_type_reg <= bus.mem_type;
            end

            start_used_reg <= bus.start          && (start_used_reg || state_reg == IDLE);
            req_used_reg   <= bus.data_request   && (req_used_reg   || state_reg == WAIT_REQ);
            done_used_reg  <= bus.done           && (done_used_reg  || state_reg == WAIT_DONE);
            inf_used_reg   <= bus.inference_done && (inf_used_reg   || state_reg == WAIT_INF);

            if (fill_enter) begin
                state_reg     <= FILL;
                b_reg         <= fill_b_next;
                j_reg         <= '0;
                len_reg       <= fill_len_next;
                mem_rd_en_reg <= 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    if (start_fire) begin
                        s_reg         <= '0;
                        mem_addr_reg  <= '0;
                        type_addr_reg <= '0;
                        busy_reg      <= 1'b1;
                    end
                end
                FILL: begin
                    if (j_reg >= len_reg - JW'(1)) begin
                        state_reg     <= DRAIN;
                        mem_rd_en_reg <= 1'b0;
                    end else begin
                        j_reg        <= j_reg + JW'(1);
                        mem_addr_reg <= mem_addr_reg + AW'(1);
                    end
                end
                DRAIN: begin
                    state_reg     <= STROBE;
                    read_done_reg <= 1'b1;
                end
                STROBE: begin
                    state_reg <= (b_reg == BW'(NB - 1)) ? WAIT_DONE : WAIT_REQ;
                end
                WAIT_REQ: begin
                    if (req_fire) begin
                        mem_addr_reg <= mem_addr_reg + AW'(1);
                    end
                end
                WAIT_DONE: begin
                    if (done_fire) begin
                        if (s_reg == L'(S - 1)) begin
                            state_reg <= WAIT_INF;
                        end else begin
                            s_reg         <= s_reg + L'(1);
                            type_addr_reg <= s_reg + L'(1);
                            mem_addr_reg  <= mem_addr_reg + AW'(1);
                        end
                    end
                end
                WAIT_INF: begin
                    if (inf_fire) begin
                        state_reg        <= REPORT;
                        result_type_reg  <= bus.inferred_type;
                        result_valid_reg <= 1'b1;
                        busy_reg         <= 1'b0;
                    end
                end
                REPORT:  state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    // One register pair per lane: filled from the read-return pipeline,
    // cleared at burst start when the lane lies beyond the burst length.
    genvar gi;
    generate
        for (gi = 0; gi < MAX_ELEMENTS; gi++) begin : g_lane
            logic [W-1:0] train_lane_reg;
            logic [W-1:0] input_lane_reg;

            // Lane write / clear.
            always_ff @(posedge clk) begin
                if (rst) begin
                    train_lane_reg <= '0;
                    input_lane_reg <= '0;
                end else if (rd_pending_reg && int'(rd_lane_reg) == gi) begin
                    train_lane_reg <= bus.mem_train_word;
                    input_lane_reg <= bus.mem_input_word;
                end else if (fill_enter && gi >= int'(fill_len_next)) begin
                    train_lane_reg <= '0;
                    input_lane_reg <= '0;
                end
            end

            assign bus.training_data[W*(gi+1)-1 -: W] = train_lane_reg;
            assign bus.input_data[W*(gi+1)-1 -: W]    = input_lane_reg;
        end
    endgenerate

    assign bus.busy               = busy_reg;
    assign bus.mem_rd_en          = mem_rd_en_reg;
    assign bus.mem_addr           = mem_addr_reg;
    assign bus.type_addr          = type_addr_reg;
    assign bus.training_data_type = train_type_reg;
    assign bus.read_done          = read_done_reg;
    assign bus.result_type        = result_type_reg;
    assign bus.result_valid       = result_valid_reg;
endmodule

// File: tb/tb_knn_load_sequencer.sv
// Directed bench for knn_load_sequencer: dut_a uses the default 5x10 matrix
// with two samples (two bursts per sample), dut_b a 2x4 matrix with four
// samples (one burst per sample). Memory returns word = address,
// input word = address + 1000 and label = sample + 1.
module tb_knn_load_sequencer;
    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   cnt;

    knn_load_sequencer_if #(.M(5), .N(10), .W(32), .MAX_ELEMENTS(32), .TYPE_W(3), .L(1)) bus_a ();
    knn_load_sequencer_if #(.M(2), .N(4),  .W(32), .MAX_ELEMENTS(32), .TYPE_W(3), .L(2)) bus_b ();

    knn_load_sequencer #(.M(5), .N(10), .W(32), .MAX_ELEMENTS(32), .TYPE_W(3), .L(1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    knn_load_sequencer #(.M(2), .N(4), .W(32), .MAX_ELEMENTS(32), .TYPE_W(3), .L(2)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model for dut_a: one-cycle read latency.
    always @(posedge clk) begin
        if (bus_a.mem_rd_en) begin
            bus_a.mem_train_word <= 32'(bus_a.mem_addr);
            bus_a.mem_input_word <= 32'(bus_a.mem_addr) + 32'd1000;
            bus_a.mem_type       <= 3'(bus_a.type_addr) + 3'd1;
        end
    end

    // Memory model for dut_b: one-cycle read latency.
    always @(posedge clk) begin
        if (bus_b.mem_rd_en) begin
            bus_b.mem_train_word <= 32'(bus_b.mem_addr);
            bus_b.mem_input_word <= 32'(bus_b.mem_addr) + 32'd1000;
            bus_b.mem_type       <= 3'(bus_b.type_addr) + 3'd1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_rd_a(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus_a.read_done && n < 100);
    endtask

    task automatic wait_rd_b(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus_b.read_done && n < 100);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus_a.start = 0; bus_a.data_request = 0; bus_a.done = 0;
        bus_a.inference_done = 0; bus_a.inferred_type = '0;
        bus_b.start = 0; bus_b.data_request = 0; bus_b.done = 0;
        bus_b.inference_done = 0; bus_b.inferred_type = '0;

        // ---- reset state ----
        repeat (3) @(negedge clk);
        check("rst_busy",      bus_a.busy, 0);
        check("rst_rd_en",     bus_a.mem_rd_en, 0);
        check("rst_read_done", bus_a.read_done, 0);
        check("rst_res_valid", bus_a.result_valid, 0);
        check("rst_lane0",     bus_a.training_data[31:0], 0);
        check("rst_addr",      bus_a.mem_addr, 0);
        $display("txn reset done");

        // ---- start on the first edge without reset ----
        rst = 1'b0;
        bus_a.start = 1;
        @(negedge clk);
        bus_a.start = 0;
        check("a_s0b0_rd_en",     bus_a.mem_rd_en, 1);
        check("a_s0b0_addr",      bus_a.mem_addr, 0);
        check("a_s0b0_busy",      bus_a.busy, 1);
        check("a_s0b0_type_addr", bus_a.type_addr, 0);

        wait_rd_a(cnt);
        $display("txn a sample0 burst0 read_done after %0d cycles", cnt);
        check("a_s0b0_latency", cnt, 33);
        for (int k = 0; k < 32; k++) begin
            check("a_s0b0_train", bus_a.training_data[32*k +: 32], k);
            check("a_s0b0_input", bus_a.input_data[32*k +: 32], k + 1000);
        end
        check("a_s0b0_type", bus_a.training_data_type, 1);

        @(negedge clk);
        check("a_read_done_pulse", bus_a.read_done, 0);

        // done during WAIT_REQ is ignored
        bus_a.done = 1;
        @(negedge clk);
        bus_a.done = 0;
        repeat (2) @(negedge clk);
        check("a_waitreq_done_rd_en", bus_a.mem_rd_en, 0);
        check("a_waitreq_busy",       bus_a.busy, 1);
        $display("txn a done ignored in WAIT_REQ");

        bus_a.data_request = 1;
        @(negedge clk);
        bus_a.data_request = 0;
        check("a_s0b1_rd_en", bus_a.mem_rd_en, 1);
        check("a_s0b1_addr",  bus_a.mem_addr, 32);

        wait_rd_a(cnt);
        $display("txn a sample0 burst1 read_done after %0d cycles", cnt);
        check("a_s0b1_latency", cnt, 19);
        for (int k = 0; k < 32; k++) begin
            check("a_s0b1_train", bus_a.training_data[32*k +: 32], (k < 18) ? 32 + k : 0);
        end
        check("a_s0b1_type", bus_a.training_data_type, 1);

        // start and data_request during WAIT_DONE are ignored
        @(negedge clk);
        bus_a.start = 1;
        bus_a.data_request = 1;
        @(negedge clk);
        bus_a.start = 0;
        bus_a.data_request = 0;
        repeat (2) @(negedge clk);
        check("a_waitdone_rd_en",     bus_a.mem_rd_en, 0);
        check("a_waitdone_read_done", bus_a.read_done, 0);
        check("a_waitdone_busy",      bus_a.busy, 1);
        $display("txn a start/data_request ignored in WAIT_DONE");

        bus_a.done = 1;
        @(negedge clk);
        bus_a.done = 0;
        check("a_s1b0_rd_en",     bus_a.mem_rd_en, 1);
        check("a_s1b0_addr",      bus_a.mem_addr, 50);
        check("a_s1b0_type_addr", bus_a.type_addr, 1);
        repeat (3) @(negedge clk);
        check("a_s1b0_addr_mid", bus_a.mem_addr, 53);

        // reset in the middle of sample 1
        rst = 1'b1;
        @(negedge clk);
        check("a_midrst_busy",      bus_a.busy, 0);
        check("a_midrst_rd_en",     bus_a.mem_rd_en, 0);
        check("a_midrst_read_done", bus_a.read_done, 0);
        check("a_midrst_lane0",     bus_a.training_data[31:0], 0);
        check("a_midrst_in_lane5",  bus_a.input_data[191:160], 0);
        check("a_midrst_type",      bus_a.training_data_type, 0);
        check("a_midrst_addr",      bus_a.mem_addr, 0);
        $display("txn a reset mid-FILL");

        rst = 1'b0;
        bus_a.start = 1;
        @(negedge clk);
        bus_a.start = 0;
        check("a_restart_rd_en", bus_a.mem_rd_en, 1);
        check("a_restart_addr",  bus_a.mem_addr, 0);
        check("a_restart_busy",  bus_a.busy, 1);
        $display("txn a restart after reset");

        // ---- dut_b: one burst per sample, data_request held high ----
        bus_b.data_request = 1;
        bus_b.start = 1;
        @(negedge clk);
        bus_b.start = 0;
        for (int s = 0; s < 4; s++) begin
            check("b_first_addr", bus_b.mem_addr, s * 8);
            wait_rd_b(cnt);
            $display("txn b sample%0d read_done after %0d cycles", s, cnt);
            check("b_latency",   cnt, 9);
            check("b_lane0",     bus_b.training_data[31:0], s * 8);
            check("b_lane7",     bus_b.training_data[255:224], s * 8 + 7);
            check("b_lane8",     bus_b.training_data[287:256], 0);
            check("b_in_lane3",  bus_b.input_data[127:96], s * 8 + 3 + 1000);
            check("b_type",      bus_b.training_data_type, s + 1);
            @(negedge clk);
            check("b_no_refill", bus_b.mem_rd_en, 0);
            repeat (2) @(negedge clk);
            check("b_req_ignored", bus_b.mem_rd_en, 0);
            bus_b.done = 1;
            @(negedge clk);
            bus_b.done = 0;
        end

        check("b_waitinf_busy",  bus_b.busy, 1);
        check("b_waitinf_valid", bus_b.result_valid, 0);
        bus_b.inferred_type = 3'd3;
        bus_b.inference_done = 1;
        @(negedge clk);
        bus_b.inference_done = 0;
        check("b_report_valid", bus_b.result_valid, 1);
        check("b_report_type",  bus_b.result_type, 3);
        check("b_report_busy",  bus_b.busy, 0);
        $display("txn b result_type=%0d", bus_b.result_type);
        @(negedge clk);
        check("b_idle_valid", bus_b.result_valid, 0);
        check("b_idle_type",  bus_b.result_type, 3);
        check("b_idle_rd_en", bus_b.mem_rd_en, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
